// File: rtl/mask_bbox_stats.sv
// Per-frame mask statistics: pixel count, coordinate sums and bounding box of
// set mask pixels, latched at each vsync rising edge. Video is passed through
// with one enabled cycle of latency.
module mask_bbox_stats #(
    parameter int W_COORD = 10,
    parameter int W_CNT   = 2*W_COORD+1,
    parameter int W_SUM   = 3*W_COORD+1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ce,
    input  logic               mask,
    input  logic               in_de,
    input  logic               in_hsync,
    input  logic               in_vsync,
    output logic               out_mask,
    output logic               out_de,
    output logic               out_hsync,
    output logic               out_vsync,
    output logic [W_COORD-1:0] x_min,
    output logic [W_COORD-1:0] x_max,
    output logic [W_COORD-1:0] y_min,
    output logic [W_COORD-1:0] y_max,
    output logic [W_CNT-1:0]   pix_count,
    output logic [W_SUM-1:0]   sum_x,
    output logic [W_SUM-1:0]   sum_y,
    output logic               obj_present,
    output logic               stats_valid
);

    localparam logic [W_COORD-1:0] COORD_MAX = '1;

    logic [W_COORD-1:0] x_cnt, y_cnt, cur_y;
    logic               prev_vs, prev_de, armed;
    logic               vs_rise, de_fall, pix;

    logic [W_CNT-1:0]   acc_cnt, acc_cnt_n;
    logic [W_SUM-1:0]   acc_sx, acc_sx_n, acc_sy, acc_sy_n;
    logic [W_COORD-1:0] acc_xmin, acc_xmin_n, acc_xmax, acc_xmax_n;
    logic [W_COORD-1:0] acc_ymin, acc_ymin_n, acc_ymax, acc_ymax_n;

    // A vsync rise clears y before use, so a pixel in the edge cycle sits on y=0
    assign vs_rise = in_vsync & ~prev_vs;
    assign de_fall = prev_de & ~in_de;
    assign pix     = in_de & mask;
    assign cur_y   = vs_rise ? '0 : y_cnt;

    // Edge detectors and registered pass-through of the video stream
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_vs   <= 1'b0;
            prev_de   <= 1'b0;
            out_mask  <= 1'b0;
            out_de    <= 1'b0;
            out_hsync <= 1'b0;
            out_vsync <= 1'b0;
        end else if (ce) begin
            prev_vs   <= in_vsync;
            prev_de   <= in_de;
            out_mask  <= mask;
            out_de    <= in_de;
            out_hsync <= in_hsync;
            out_vsync <= in_vsync;
        end
    end

    // Pixel coordinate counters; x restarts every line, y restarts every frame
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_cnt <= '0;
            y_cnt <= '0;
        end else if (ce) begin
            if (!in_de)
                x_cnt <= '0;
            else if (x_cnt != COORD_MAX)
                x_cnt <= x_cnt + 1'b1;
            if (vs_rise)
                y_cnt <= '0;
            else if (de_fall && y_cnt != COORD_MAX)
                y_cnt <= y_cnt + 1'b1;
        end
    end

    // Next accumulator values: restart from init at a frame edge, then fold in the pixel
    always_comb begin
        acc_cnt_n  = vs_rise ? '0 : acc_cnt;
        acc_sx_n   = vs_rise ? '0 : acc_sx;
        acc_sy_n   = vs_rise ? '0 : acc_sy;
        acc_xmin_n = vs_rise ? '1 : acc_xmin;
        acc_xmax_n = vs_rise ? '0 : acc_xmax;
        acc_ymin_n = vs_rise ? '1 : acc_ymin;
        acc_ymax_n = vs_rise ? '0 : acc_ymax;
        if (pix) begin
            acc_cnt_n = acc_cnt_n + W_CNT'(1);
            acc_sx_n  = acc_sx_n + {{(W_SUM-W_COORD){1'b0}}, x_cnt};
            acc_sy_n  = acc_sy_n + {{(W_SUM-W_COORD){1'b0}}, cur_y};
            if (x_cnt < acc_xmin_n) acc_xmin_n = x_cnt;
            if (x_cnt > acc_xmax_n) acc_xmax_n = x_cnt;
            if (cur_y < acc_ymin_n) acc_ymin_n = cur_y;
            if (cur_y > acc_ymax_n) acc_ymax_n = cur_y;
        end
    end

    // Accumulator registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_cnt  <= '0;
            acc_sx   <= '0;
            acc_sy   <= '0;
            acc_xmin <= '1;
            acc_xmax <= '0;
            acc_ymin <= '1;
            acc_ymax <= '0;
        end else if (ce) begin
            acc_cnt  <= acc_cnt_n;
            acc_sx   <= acc_sx_n;
            acc_sy   <= acc_sy_n;
            acc_xmin <= acc_xmin_n;
            acc_xmax <= acc_xmax_n;
            acc_ymin <= acc_ymin_n;
            acc_ymax <= acc_ymax_n;
        end
    end

    // Result latch at frame edges; the first edge after reset only arms
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed       <= 1'b0;
            stats_valid <= 1'b0;
            pix_count   <= '0;
            sum_x       <= '0;
            sum_y       <= '0;
            x_min       <= '0;
            x_max       <= '0;
            y_min       <= '0;
            y_max       <= '0;
            obj_present <= 1'b0;
        end else begin
            stats_valid <= 1'b0;
            if (ce && vs_rise) begin
                armed <= 1'b1;
                if (armed) begin
                    stats_valid <= 1'b1;
                    pix_count   <= acc_cnt;
                    sum_x       <= acc_sx;
                    sum_y       <= acc_sy;
                    obj_present <= (acc_cnt != '0);
                    if (acc_cnt == '0) begin
                        x_min <= '0;
                        x_max <= '0;
                        y_min <= '0;
                        y_max <= '0;
                    end else begin
                        x_min <= acc_xmin;
                        x_max <= acc_xmax;
                        y_min <= acc_ymin;
                        y_max <= acc_ymax;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_mask_bbox_stats.sv
// Directed self-checking bench for mask_bbox_stats.
module tb_mask_bbox_stats;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        mask, in_de, in_hsync, in_vsync;
    logic        out_mask, out_de, out_hsync, out_vsync;
    logic [9:0]  x_min, x_max, y_min, y_max;
    logic [20:0] pix_count;
    logic [30:0] sum_x, sum_y;
    logic        obj_present, stats_valid;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    bit gaps   = 1'b0;
    logic last_m, last_de, last_hs, last_vs;

    mask_bbox_stats dut (
        .clk(clk), .rst(rst), .ce(ce), .mask(mask),
        .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
        .out_mask(out_mask), .out_de(out_de), .out_hsync(out_hsync), .out_vsync(out_vsync),
        .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
        .pix_count(pix_count), .sum_x(sum_x), .sum_y(sum_y),
        .obj_present(obj_present), .stats_valid(stats_valid)
    );

    // 100 MHz pixel clock
    always #5 clk = ~clk;

    // Count stats_valid pulses, sampled mid-cycle
    always @(negedge clk) if (stats_valid === 1'b1) pulses++;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_out_mask"}, 64'(out_mask), 64'd0);
        chk({tag, "_out_de"}, 64'(out_de), 64'd0);
        chk({tag, "_out_hsync"}, 64'(out_hsync), 64'd0);
        chk({tag, "_out_vsync"}, 64'(out_vsync), 64'd0);
        chk({tag, "_x_min"}, 64'(x_min), 64'd0);
        chk({tag, "_x_max"}, 64'(x_max), 64'd0);
        chk({tag, "_y_min"}, 64'(y_min), 64'd0);
        chk({tag, "_y_max"}, 64'(y_max), 64'd0);
        chk({tag, "_pix_count"}, 64'(pix_count), 64'd0);
        chk({tag, "_sum_x"}, 64'(sum_x), 64'd0);
        chk({tag, "_sum_y"}, 64'(sum_y), 64'd0);
        chk({tag, "_obj_present"}, 64'(obj_present), 64'd0);
        chk({tag, "_stats_valid"}, 64'(stats_valid), 64'd0);
    endtask

    // One enabled pixel cycle; in gap mode random ce-low cycles are inserted first
    task automatic apply_stimulus(input logic de, input logic hs, input logic vs, input logic m);
        int n;
        in_de = de; in_hsync = hs; in_vsync = vs; mask = m;
        n = 0;
        if (gaps) begin
            while (n < 16 && $urandom_range(0, 1) == 0) begin
                ce = 1'b0;
                @(posedge clk); #1;
                chk("hold_mask", 64'(out_mask), 64'(last_m));
                chk("hold_vsync", 64'(out_vsync), 64'(last_vs));
                n++;
            end
        end
        ce = 1'b1;
        @(posedge clk); #1;
        if (gaps) begin
            chk("pass_mask", 64'(out_mask), 64'(m));
            chk("pass_de", 64'(out_de), 64'(de));
            chk("pass_hsync", 64'(out_hsync), 64'(hs));
            chk("pass_vsync", 64'(out_vsync), 64'(vs));
        end
        last_m = m; last_de = de; last_hs = hs; last_vs = vs;
    endtask

    function automatic logic pix_at(input int mode, input int x, input int y);
        case (mode)
            1:       return 1'b1;
            2:       return (x == 3 && y == 2);
            4:       return (y == 0 && x < 5);
            5:       return (x == 1 && y == 0) || (x == 6 && y == 1);
            default: return 1'b0;
        endcase
    endfunction

    task automatic send_frame(input int w, input int h, input int mode);
        for (int y = 0; y < h; y++) begin
            for (int x = 0; x < w; x++) apply_stimulus(1'b1, 1'b0, 1'b0, pix_at(mode, x, y));
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0);
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Vsync rise, then the result checks one cycle after the first vsync sample
    task automatic check_output(input string tag, input logic edge_pix, input logic exp_valid,
                                input int cnt, input int sx, input int sy,
                                input int xmn, input int xmx, input int ymn, input int ymx);
        int p0;
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        p0 = pulses;
        apply_stimulus(edge_pix, 1'b0, 1'b1, edge_pix);
        chk({tag, "_stats_valid"}, 64'(stats_valid), 64'(exp_valid));
        chk({tag, "_pix_count"}, 64'(pix_count), 64'(cnt));
        chk({tag, "_sum_x"}, 64'(sum_x), 64'(sx));
        chk({tag, "_sum_y"}, 64'(sum_y), 64'(sy));
        chk({tag, "_x_min"}, 64'(x_min), 64'(xmn));
        chk({tag, "_x_max"}, 64'(x_max), 64'(xmx));
        chk({tag, "_y_min"}, 64'(y_min), 64'(ymn));
        chk({tag, "_y_max"}, 64'(y_max), 64'(ymx));
        chk({tag, "_obj_present"}, 64'(obj_present), 64'(cnt != 0));
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_pulses"}, 64'(pulses - p0), 64'(exp_valid));
    endtask

    initial begin
        $display("[TB] start");
        rst = 1'b0; ce = 1'b0; mask = 1'b0;
        in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
        last_m = 1'b0; last_de = 1'b0; last_hs = 1'b0; last_vs = 1'b0;
        #1;
        check_zero("reset");
        #20 rst = 1'b1;
        @(posedge clk); #1;

        // Partial first frame is discarded by the arming edge
        send_frame(8, 2, 4);
        check_output("arm", 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);

        send_frame(8, 2, 5);
        check_output("two_pix", 1'b0, 1'b1, 2, 7, 1, 1, 6, 0, 1);

        send_frame(8, 4, 2);
        check_output("single", 1'b0, 1'b1, 1, 3, 2, 3, 3, 2, 2);

        send_frame(4, 4, 1);
        check_output("full", 1'b0, 1'b1, 16, 24, 24, 0, 3, 0, 3);

        // Empty frame; the pixel on its closing edge opens the next frame at (0,0)
        send_frame(8, 4, 0);
        check_output("empty", 1'b1, 1'b1, 0, 0, 0, 0, 0, 0, 0);

        // Line 2 of this frame has y=3 because the edge pixel's de fall bumped y
        send_frame(8, 4, 2);
        check_output("edge_pix", 1'b0, 1'b1, 2, 3, 3, 0, 3, 0, 3);

        gaps = 1'b1;
        send_frame(8, 4, 2);
        check_output("ce_gaps", 1'b0, 1'b1, 1, 3, 2, 3, 3, 2, 2);
        gaps = 1'b0;

        // Async reset between edges mid-frame
        send_frame(8, 1, 1);
        #2 rst = 1'b0;
        #1;
        check_zero("async_rst");
        @(negedge clk) rst = 1'b1;
        send_frame(8, 2, 1);
        check_output("rearm", 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 0);
        send_frame(8, 2, 5);
        check_output("after_rst", 1'b0, 1'b1, 2, 7, 1, 1, 6, 0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        errors++;
        $display("[TB] FAIL timeout got running expected finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
